// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer
// Queues (source, destination) register-transfer requests. For each one it
// drives a one-hot bus select for the source, then a one-hot load enable for
// the destination. Each valid transfer takes two cycles (DRIVE, LATCH), and
// back-to-back transfers run with no idle cycle between them. An entry with
// an out-of-range index is dropped and reported with a one-cycle err pulse.
module bus_transfer_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NSRC  = 24
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [4:0]              req_src,
    input  logic [4:0]              req_dst,
    output logic [31:0]             bus_select,
    output logic [31:0]             load_en,
    output logic                    xfer_done,
    output logic                    err,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Indices 22 (in.port) and 23 (C sign-extended) are read-only.
    localparam logic [5:0]    SRC_LIMIT  = 6'(NSRC);
    localparam logic [5:0]    DST_LIMIT  = 6'd22;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Select and enable bits 31:24 have no register behind them.
    localparam logic [31:0]   MAP_MASK   = 32'h00FF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LATCH
    } state_t;

    // Request FIFO storage: {src, dst}
    logic [9:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  rd_ptr_d;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    logic [4:0]     head_src;
    logic [4:0]     head_dst;
    logic           head_ok;

    // Sequencer state and registered outputs
    state_t         state_q;
    logic [4:0]     dst_q;
    logic [31:0]    bus_select_q;
    logic [31:0]    load_en_q;
    logic           xfer_done_q;
    logic           err_q;

    function automatic logic [31:0] onehot(input logic [4:0] idx);
        onehot = (32'd1 << idx) & MAP_MASK;
    endfunction

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Only fullness gates a push, so a pop in the same cycle does not free
    // a slot early.
    assign push = req_valid && !full;

    // The head is consumed whenever the sequencer can start a new transfer.
    // It can do so in IDLE and also in LATCH, which is why back-to-back
    // transfers have no idle cycle.
    assign pop  = !empty && (state_q != DRIVE);

    assign {head_src, head_dst} = mem_q[rd_ptr_q];
    assign head_ok = ({1'b0, head_src} < SRC_LIMIT) && ({1'b0, head_dst} < DST_LIMIT);

    // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage write; contents need no reset because occupancy guards reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_src, req_dst};
        end
    end

    // Transfer sequencer with registered select/enable/pulse outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            dst_q        <= '0;
            bus_select_q <= '0;
            load_en_q    <= '0;
            xfer_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            xfer_done_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                DRIVE: begin
                    // Source stays on the bus while the destination latches.
                    state_q     <= LATCH;
                    load_en_q   <= onehot(dst_q);
                    xfer_done_q <= 1'b1;
                end
                default: begin
                    // IDLE and LATCH share the same exit decision. LATCH ends
                    // its transfer here, so it behaves like IDLE with a pending
                    // pop.
                    state_q      <= IDLE;
                    bus_select_q <= '0;
                    load_en_q    <= '0;
                    if (pop) begin
                        if (head_ok) begin
                            state_q      <= DRIVE;
                            dst_q        <= head_dst;
                            bus_select_q <= onehot(head_src);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign req_ready  = !full;
    assign bus_select = bus_select_q;
    assign load_en    = load_en_q;
    assign xfer_done  = xfer_done_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE) || !empty;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Testbench for bus_transfer_sequencer.
// The driver records every accepted request in a scoreboard queue. A monitor
// runs on the falling clock edge and checks each observed phase against the
// queue head. The phase checks are: err for an invalid request, DRIVE with the
// source select, and LATCH with the select plus the destination enable.
// Separately, a transaction-level occupancy model checks fifo_count,
// req_ready, busy and the no-gap sequencing rules.
module tb_bus_transfer_sequencer;

    localparam int DEPTH = 4;
    localparam int NSRC  = 24;

    logic        clk;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;
    logic [31:0] bus_select;
    logic [31:0] load_en;
    logic        xfer_done;
    logic        err;
    logic        busy;
    logic [2:0]  fifo_count;

    bus_transfer_sequencer #(
        .DEPTH (DEPTH),
        .NSRC  (NSRC)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .bus_select (bus_select),
        .load_en    (load_en),
        .xfer_done  (xfer_done),
        .err        (err),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int checks   = 0;
    int failures = 0;

    logic [9:0] sb[$];

    int  occ;
    int  inflight;
    int  prev_occ   = 0;
    bit  prev_drive = 0;
    bit  is_drive;
    int  max_occ    = 0;
    int  xfer_cnt   = 0;
    int  stall_cnt  = 0;
    logic [9:0] fr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit valid_req(input logic [4:0] s, input logic [4:0] d);
        return (int'(s) < NSRC) && (int'(d) < 22);
    endfunction

    function automatic logic [31:0] sel_of(input logic [4:0] idx);
        logic [31:0] one;
        one = 32'd1;
        return one << idx;
    endfunction

    // Monitor: compare observed phase against the scoreboard head
    always @(negedge clk) begin
        if (clr) begin
            prev_drive = 0;
            prev_occ   = 0;
        end else begin
            inflight = (bus_select != 32'd0) ? 1 : 0;
            occ = int'(sb.size()) - inflight - (err ? 1 : 0);
            if (occ > max_occ) max_occ = occ;
            chk("fifo_count", 32'(fifo_count), 32'(occ));
            chk("req_ready", 32'(req_ready), 32'(occ < DEPTH));
            chk("busy", 32'(busy), 32'((occ > 0) || (inflight != 0)));
            is_drive = (bus_select != 32'd0) && !xfer_done;
            if (prev_drive)
                chk("drive_then_latch", 32'(xfer_done), 32'd1);
            else if (prev_occ > 0)
                chk("start_no_gap", 32'(is_drive || err), 32'd1);
            else
                chk("stay_idle", 32'((bus_select != 0) || (load_en != 0) || xfer_done || err), 32'd0);

            if (err || is_drive || xfer_done) begin
                chk("pending_item", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    fr = sb[0];
                    if (err) begin
                        chk("err_for_invalid", 32'(valid_req(fr[9:5], fr[4:0])), 32'd0);
                        chk("err_no_select", bus_select | load_en, 32'd0);
                        chk("err_no_done", 32'(xfer_done), 32'd0);
                        void'(sb.pop_front());
                    end else if (is_drive) begin
                        chk("drive_valid", 32'(valid_req(fr[9:5], fr[4:0])), 32'd1);
                        chk("drive_select", bus_select, sel_of(fr[9:5]));
                        chk("drive_load", load_en, 32'd0);
                    end else begin
                        chk("latch_select", bus_select, sel_of(fr[9:5]));
                        chk("latch_load", load_en, sel_of(fr[4:0]));
                        void'(sb.pop_front());
                        xfer_cnt++;
                    end
                end
            end else begin
                chk("idle_load", load_en, 32'd0);
            end
            prev_drive = is_drive;
            prev_occ   = occ;
        end
    end

    // Offer one request; hold it until accepted (bounded)
    task automatic push(input logic [4:0] s, input logic [4:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        #1;
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        while (!req_ready && guard < 200) begin
            stall_cnt++;
            guard++;
            @(negedge clk);
            #1;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles, required 1", guard);
            req_valid = 1'b0;
        end else begin
            sb.push_back({s, d});
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_reached", 32'(sb.size() == 0 && !busy), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int done_seen;
        logic [4:0] s;
        logic [4:0] d;

        clr       = 1'b1;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        repeat (2) @(negedge clk);
        chk("rst_select", bus_select, 32'd0);
        chk("rst_load", load_en, 32'd0);
        chk("rst_done", 32'(xfer_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        #1 clr = 1'b0;

        // single transfer
        push(5'd3, 5'd16);
        wait_idle();

        // back-to-back
        push(5'd20, 5'd21);
        push(5'd21, 5'd0);
        push(5'd17, 5'd5);
        wait_idle();

        // full FIFO: continuous pushes outrun the 2-cycle drain
        max_occ   = 0;
        stall_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            push(5'($urandom_range(0, NSRC - 1)), 5'($urandom_range(0, 21)));
        end
        wait_idle();
        chk("max_occupancy", 32'(max_occ), 32'(DEPTH));
        chk("ready_dropped", 32'(stall_cnt > 0), 32'd1);

        // invalid entries
        push(5'd24, 5'd1);
        push(5'd2, 5'd22);
        push(5'd2, 5'd3);
        wait_idle();

        // async reset during LATCH of 7->8 with two entries queued
        push(5'd7, 5'd8);
        push(5'd1, 5'd2);
        push(5'd3, 5'd4);
        chk("pre_clr_latch_load", load_en, 32'h100);
        chk("pre_clr_latch_done", 32'(xfer_done), 32'd1);
        chk("pre_clr_count", 32'(fifo_count), 32'd2);
        #1 clr = 1'b1;
        #1;
        chk("clr_load_now", load_en, 32'd0);
        chk("clr_select_now", bus_select, 32'd0);
        chk("clr_done_now", 32'(xfer_done), 32'd0);
        chk("clr_count_now", 32'(fifo_count), 32'd0);
        chk("clr_ready_now", 32'(req_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        #1 clr = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (xfer_done) done_seen++;
        end
        chk("no_done_after_clr", 32'(done_seen), 32'd0);

        // wrap-around: 10 valid requests back to back
        base = xfer_cnt;
        for (int i = 0; i < 10; i++) begin
            push(5'((i * 5 + 1) % NSRC), 5'((i * 3 + 2) % 22));
        end
        wait_idle();
        chk("wrap_xfer_count", 32'(xfer_cnt - base), 32'd10);

        // randomized mix of valid/invalid requests with random gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) s = 5'($urandom_range(0, 31));
            else                           s = 5'($urandom_range(0, NSRC - 1));
            if ($urandom_range(0, 3) == 0) d = 5'($urandom_range(0, 31));
            else                           d = 5'($urandom_range(0, 21));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(s, d);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
